ram_write_arbiter: RTL and testbench
====================================

RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 19, game-state RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, game-state RAM data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 15, max consecutive cycles gst may be denied while requesting (legal range 1..255).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports:
- clk_i  input  1  sole clock; all state updates on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- gst_req_i  input  1  game-state controller write request.
- gst_addr_i  input  ADDR_WIDTH  gst write address.
- gst_data_i  input  DATA_WIDTH  gst write data.
- gst_gnt_o  output  1  gst write accepted this cycle.
- mpd_req_i  input  1  mouse pixel drawer write request.
- mpd_addr_i  input  ADDR_WIDTH  mpd write address.
- mpd_data_i  input  DATA_WIDTH  mpd write data.
- mpd_gnt_o  output  1  mpd write accepted this cycle.
- ram_wr_en_o  output  1  RAM write enable, registered.
- ram_wr_address_o  output  ADDR_WIDTH  RAM write address, registered.
- ram_wr_data_o  output  DATA_WIDTH  RAM write data, registered.

Function
REQ-005 SHALL treat a transfer as occurring on any cycle with req and gnt both high; the requester holds addr/data stable while req is high and gnt is low.
REQ-006 SHALL make gnt outputs combinational from current state and req inputs; gst_gnt_o and mpd_gnt_o never high together.
REQ-007 SHALL drive ram_wr_en_o/address/data exactly 1 cycle after a transfer, carrying the granted requester's addr/data; ram_wr_en_o low in every other cycle.
REQ-008 SHALL implement FSM states IDLE, SERVE_MPD, SERVE_GST, FORCE_GST; state = owner of the current cycle's grant.
REQ-009 SHALL arbitrate: no req -> IDLE, no grant; one req -> grant it; both req -> grant mpd unless starve_cnt == STARVE_LIMIT, then FORCE_GST grants gst.
REQ-010 SHALL hold FORCE_GST for exactly one cycle, then re-arbitrate per REQ-009.
REQ-011 SHALL keep an 8-bit starve_cnt: +1 each cycle gst_req_i high and gst not granted; cleared when gst granted or gst_req_i low; saturates at STARVE_LIMIT.
REQ-012 SHALL guarantee any continuously asserted gst request is granted within STARVE_LIMIT+1 cycles.
REQ-013 SHALL deassert a requester's req without penalty; a dropped request is not remembered.

Reset
REQ-014 SHALL, while reset_i high: state = IDLE, starve_cnt = 0, gnt outputs 0, ram_wr_en_o = 0 on next edge, ram_wr_address_o = 0, ram_wr_data_o = 0.
REQ-015 SHALL drop a transfer granted in the cycle reset asserts; no RAM write follows it.

Configuration
REQ-016 SHALL, with macro RAM_ARB_STATS_EN defined, add outputs conflict_count_o (16 bit, +1 per cycle both reqs high, saturating) and force_count_o (16 bit, +1 per FORCE_GST entry, saturating), both cleared by reset.
REQ-017 SHALL, without RAM_ARB_STATS_EN, omit those ports and counters; arbitration behaviour identical.

Structure
REQ-018 SHALL place the FSM state enum (arb_state_t) and the requester index constants (REQ_GST=0, REQ_MPD=1) in shared package ram_arb_pkg.
REQ-019 SHALL be a single module; the starvation counter may be a sub-module named starve_counter.

Verification
REQ-020 Only gst_req_i=1, addr=0x00100, data=1 -> gst_gnt_o=1 same cycle; next cycle ram_wr_en_o=1, addr 0x00100, data 1.
REQ-021 Both req held, STARVE_LIMIT=15 -> mpd granted 15 cycles, gst granted cycle 16 (FORCE_GST), mpd cycle 17; repeats with period 16.
REQ-022 gst_req pulses low after 10 denied cycles, then high -> starve_cnt restarts at 0; gst waits full 15 cycles again.
REQ-023 Reset asserted in a cycle with mpd_gnt_o=1 -> next cycle ram_wr_en_o=0, state IDLE, starve_cnt 0.
REQ-024 Random req/addr/data for 10000 cycles -> never both gnts high; every RAM write matches a granted transfer in order; no gst wait exceeds 16 cycles.
REQ-025 RAM_ARB_STATS_EN defined, both req held 32 cycles from reset -> conflict_count_o=32, force_count_o=2.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the game-state / mouse-pixel RAM write arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_MPD = 2'd1,
        SERVE_GST = 2'd2,
        FORCE_GST = 2'd3
    } arb_state_t;

    localparam int REQ_GST      = 0;
    localparam int REQ_MPD      = 1;
    localparam int NUM_REQ      = 2;
    localparam int STARVE_CNT_W = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ram_write_arbiter_starve_counter.sv
// Counts consecutive cycles the game-state controller is kept waiting; saturates at STARVE_LIMIT.
module starve_counter
    import ram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic gst_req_i,
    input  logic gst_gnt_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_VAL = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [STARVE_CNT_W-1:0] starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        // A dropped or served request forgets its history entirely.
        if (!gst_req_i || gst_gnt_i) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < LIMIT_VAL) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign at_limit_o = (starve_cnt_q == LIMIT_VAL);

endmodule

// File: rtl/ram_write_arbiter.sv
// Two-requester RAM write arbiter: mouse drawer has priority, game-state is forced through on starvation.
// Optional statistics counters are enabled with the RAM_ARB_STATS_EN macro.
module ram_write_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  gst_req_i,
    input  logic [ADDR_WIDTH-1:0] gst_addr_i,
    input  logic [DATA_WIDTH-1:0] gst_data_i,
    output logic                  gst_gnt_o,
    input  logic                  mpd_req_i,
    input  logic [ADDR_WIDTH-1:0] mpd_addr_i,
    input  logic [DATA_WIDTH-1:0] mpd_data_i,
    output logic                  mpd_gnt_o,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]           conflict_count_o,
    output logic [15:0]           force_count_o
`endif
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic                  at_limit;
    logic [NUM_REQ-1:0]    gnt;
    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  ram_wr_en_q;
    logic                  ram_wr_en_d;
    logic [ADDR_WIDTH-1:0] ram_wr_address_q;
    logic [ADDR_WIDTH-1:0] ram_wr_address_d;
    logic [DATA_WIDTH-1:0] ram_wr_data_q;
    logic [DATA_WIDTH-1:0] ram_wr_data_d;

    assign req_addr[REQ_GST] = gst_addr_i;
    assign req_addr[REQ_MPD] = mpd_addr_i;
    assign req_data[REQ_GST] = gst_data_i;
    assign req_data[REQ_MPD] = mpd_data_i;

    // state_d is the owner of this cycle's grant; state_q remembers last cycle's owner.
    always_comb begin
        state_d = IDLE;
        if (reset_i) begin
            state_d = IDLE;
        end else if (gst_req_i && mpd_req_i) begin
            state_d = (at_limit && (state_q != FORCE_GST)) ? FORCE_GST : SERVE_MPD;
        end else if (gst_req_i) begin
            state_d = SERVE_GST;
        end else if (mpd_req_i) begin
            state_d = SERVE_MPD;
        end
    end

    assign gnt[REQ_GST] = (state_d == SERVE_GST) || (state_d == FORCE_GST);
    assign gnt[REQ_MPD] = (state_d == SERVE_MPD);
    assign gst_gnt_o    = gnt[REQ_GST];
    assign mpd_gnt_o    = gnt[REQ_MPD];

    // One-hot grant, so an AND-OR mux selects the winning payload.
    logic [ADDR_WIDTH-1:0] addr_terms [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_terms [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_payload
            assign addr_terms[gi] = req_addr[gi] & {ADDR_WIDTH{gnt[gi]}};
            assign data_terms[gi] = req_data[gi] & {DATA_WIDTH{gnt[gi]}};
        end
    endgenerate

    assign sel_addr = addr_terms[REQ_GST] | addr_terms[REQ_MPD];
    assign sel_data = data_terms[REQ_GST] | data_terms[REQ_MPD];

    always_comb begin
        ram_wr_en_d      = |gnt;
        ram_wr_address_d = ram_wr_address_q;
        ram_wr_data_d    = ram_wr_data_q;
        if (|gnt) begin
            ram_wr_address_d = sel_addr;
            ram_wr_data_d    = sel_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= IDLE;
            ram_wr_en_q      <= 1'b0;
            ram_wr_address_q <= '0;
            ram_wr_data_q    <= '0;
        end else begin
            state_q          <= state_d;
            ram_wr_en_q      <= ram_wr_en_d;
            ram_wr_address_q <= ram_wr_address_d;
            ram_wr_data_q    <= ram_wr_data_d;
        end
    end

    assign ram_wr_en_o      = ram_wr_en_q;
    assign ram_wr_address_o = ram_wr_address_q;
    assign ram_wr_data_o    = ram_wr_data_q;

    starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .gst_req_i (gst_req_i),
        .gst_gnt_i (gnt[REQ_GST]),
        .at_limit_o(at_limit)
    );

`ifdef RAM_ARB_STATS_EN
    logic [15:0] conflict_count_q;
    logic [15:0] conflict_count_d;
    logic [15:0] force_count_q;
    logic [15:0] force_count_d;

    always_comb begin
        conflict_count_d = conflict_count_q;
        force_count_d    = force_count_q;
        if (gst_req_i && mpd_req_i) begin
            conflict_count_d = sat_inc16(conflict_count_q);
        end
        if ((state_d == FORCE_GST) && (state_q != FORCE_GST)) begin
            force_count_d = sat_inc16(force_count_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            conflict_count_q <= '0;
            force_count_q    <= '0;
        end else begin
            conflict_count_q <= conflict_count_d;
            force_count_q    <= force_count_d;
        end
    end

    assign conflict_count_o = conflict_count_q;
    assign force_count_o    = force_count_q;
`endif

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Self-checking bench for ram_write_arbiter: directed scenarios followed by a randomized run against a reference model.
module tb_ram_write_arbiter;

    localparam int AW    = 19;
    localparam int DW    = 1;
    localparam int LIMIT = 15;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          gst_req_i = 1'b0;
    logic [AW-1:0] gst_addr_i = '0;
    logic [DW-1:0] gst_data_i = '0;
    logic          gst_gnt_o;
    logic          mpd_req_i = 1'b0;
    logic [AW-1:0] mpd_addr_i = '0;
    logic [DW-1:0] mpd_data_i = '0;
    logic          mpd_gnt_o;
    logic          ram_wr_en_o;
    logic [AW-1:0] ram_wr_address_o;
    logic [DW-1:0] ram_wr_data_o;
`ifdef RAM_ARB_STATS_EN
    logic [15:0]   conflict_count_o;
    logic [15:0]   force_count_o;
`endif

    always #5 clk_i = ~clk_i;

    ram_write_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .gst_req_i       (gst_req_i),
        .gst_addr_i      (gst_addr_i),
        .gst_data_i      (gst_data_i),
        .gst_gnt_o       (gst_gnt_o),
        .mpd_req_i       (mpd_req_i),
        .mpd_addr_i      (mpd_addr_i),
        .mpd_data_i      (mpd_data_i),
        .mpd_gnt_o       (mpd_gnt_o),
        .ram_wr_en_o     (ram_wr_en_o),
        .ram_wr_address_o(ram_wr_address_o),
        .ram_wr_data_o   (ram_wr_data_o)
`ifdef RAM_ARB_STATS_EN
        ,
        .conflict_count_o(conflict_count_o),
        .force_count_o   (force_count_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: length of the gst's current unbroken wait, and last written payload.
    int            streak = 0;
    int            dut_wait = 0;
    logic [AW-1:0] hold_addr = '0;
    logic [DW-1:0] hold_data = '0;
    logic          last_g;
    logic          last_m;
    bit            log_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic gr, input logic [AW-1:0] ga, input logic [DW-1:0] gd,
                        input logic mr, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        logic exp_g;
        logic exp_m;
        reset_i    = rst;
        gst_req_i  = gr;
        gst_addr_i = ga;
        gst_data_i = gd;
        mpd_req_i  = mr;
        mpd_addr_i = ma;
        mpd_data_i = md;
        #1;
        // Rules: lone request wins; on conflict mpd wins unless gst has already waited LIMIT cycles.
        exp_g = !rst && gr && (!mr || (streak >= LIMIT));
        exp_m = !rst && mr && !exp_g;
        chk("gst_gnt", 32'(gst_gnt_o), 32'(exp_g));
        chk("mpd_gnt", 32'(mpd_gnt_o), 32'(exp_m));
        last_g = gst_gnt_o;
        last_m = mpd_gnt_o;
        if (!rst && gr) begin
            if (gst_gnt_o === 1'b1) begin
                chk("gst_wait_bound", 32'(dut_wait <= LIMIT), 32'd1);
                dut_wait = 0;
            end else begin
                dut_wait++;
            end
        end else begin
            dut_wait = 0;
        end
        @(posedge clk_i);
        #1;
        if (rst) begin
            hold_addr = '0;
            hold_data = '0;
        end else if (exp_g) begin
            hold_addr = ga;
            hold_data = gd;
        end else if (exp_m) begin
            hold_addr = ma;
            hold_data = md;
        end
        chk("ram_wr_en", 32'(ram_wr_en_o), 32'(!rst && (exp_g || exp_m)));
        chk("ram_wr_address", 32'(ram_wr_address_o), 32'(hold_addr));
        chk("ram_wr_data", 32'(ram_wr_data_o), 32'(hold_data));
        if (log_en && ram_wr_en_o === 1'b1)
            $display("write %s addr=%05h data=%0d", exp_g ? "gst" : "mpd", ram_wr_address_o, ram_wr_data_o);
        streak = (rst || !gr || exp_g) ? 0 : streak + 1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("reset_ram_en", 32'(ram_wr_en_o), 32'd0);
        chk("reset_ram_addr", 32'(ram_wr_address_o), 32'd0);

        // Lone gst write: same-cycle grant, write one cycle later
        step(1'b0, 1'b1, 19'h00100, 1'b1, 1'b0, '0, '0);
        chk("lone_gst_gnt", 32'(last_g), 32'd1);
        chk("lone_gst_en", 32'(ram_wr_en_o), 32'd1);
        chk("lone_gst_addr", 32'(ram_wr_address_o), 32'h00100);
        chk("lone_gst_data", 32'(ram_wr_data_o), 32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("idle_no_write", 32'(ram_wr_en_o), 32'd0);

        // Both requesting: gst forced through every 16th cycle
        do_reset();
        for (int i = 1; i <= 34; i++) begin
            step(1'b0, 1'b1, 19'(i), 1'b1, 1'b1, 19'(i + 1000), 1'b0);
            chk("force_period_gst", 32'(last_g), 32'(i % 16 == 0));
        end

        // Dropping gst after 10 denials restarts its wait
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 19'h1, 1'b1, 1'b1, 19'h2, 1'b0);
        step(1'b0, 1'b0, 19'h1, 1'b1, 1'b1, 19'h2, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 1'b1, 19'h3, 1'b1, 1'b1, 19'h4, 1'b0);
            chk("restart_wait_gst", 32'(last_g), 32'(i == 16));
        end

        // Reset arriving while mpd holds the grant drops the transfer
        do_reset();
        step(1'b0, 1'b0, '0, '0, 1'b1, 19'h55, 1'b1);
        chk("pre_reset_mpd_gnt", 32'(last_m), 32'd1);
        step(1'b1, 1'b0, '0, '0, 1'b1, 19'h66, 1'b1);
        chk("reset_drops_write", 32'(ram_wr_en_o), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 19'h7, 1'b0, 1'b1, 19'h8, 1'b1);
            chk("post_reset_starve", 32'(last_g), 32'(i == 16));
        end

`ifdef RAM_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 19'h9, 1'b1, 1'b1, 19'hA, 1'b0);
        chk("conflict_count", 32'(conflict_count_o), 32'd32);
        chk("force_count", 32'(force_count_o), 32'd2);
`endif

        // Randomized traffic, requests biased high to provoke conflicts and starvation
        log_en = 1'b0;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 3) != 0), AW'($urandom), DW'($urandom),
                 ($urandom_range(0, 7) != 0), AW'($urandom), DW'($urandom));
            chk("gnt_exclusive", 32'(last_g & last_m), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
